control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  MIPS ID-stage main decoder: maps opcode/funct to datapath control for the ID/EX register.
//  Outputs are registered: one-cycle latency, one clock, synchronous active-high reset.
//  i_control_mux=0 forces a bubble (all-zero controls) for hazard/stall insertion.
// PARAMETERS
//  none. Encodings are fixed as listed below.
// PORTS
//  clk             in   1  clock; all state updates on rising edge
//  rst             in   1  synchronous active-high reset
//  i_opcode        in   6  instr[31:26]
//  i_funct         in   6  instr[5:0]; used only when i_opcode=6'h00
//  i_control_mux   in   1  1=decode normally, 0=insert bubble
//  o_RegDst        out  1  1=rd, 0=rt write destination
//  o_RegWrite      out  1  register-file write enable
//  o_MemRead       out  1  data-memory read
//  o_MemWrite      out  1  data-memory write
//  o_MemtoReg      out  1  1=writeback from memory
//  o_ALUOp         out  4  ALU operation code
//  o_ALUSrc        out  1  1=ALU B from sign/zero-extended immediate
//  o_Shamt         out  1  1=ALU A from shamt field (constant shifts)
//  o_ls_filter_op  out  3  load/store width/sign filter
//  o_illegal       out  1  only when CONTROL_ILLEGAL_DETECT_EN defined
// BEHAVIOUR
//  Reset: every output 0. Outputs update each rising edge from current inputs (latency 1).
//  i_control_mux=0 (not in reset): next outputs all 0 regardless of opcode/funct.
//  ALUOp: SLL=0 SRL=1 SRA=2 ADD=3 SUB=4 AND=5 OR=6 XOR=7 NOR=8 SLT=9 LUI=A ADDU=B SUBU=C.
//  ls_filter_op: LB/SB=000 LH/SH=001 LW/SW=010 LBU=011 LHU=100; non-memory=010.
//  Signals not listed for a class are 0; ALUOp defaults to ADD(3), filter to 010.
//  R-type (op 00), funct: SLL 00,SRL 02,SRA 03 -> RegDst=1 RegWrite=1 Shamt=1, ALUOp shift.
//   SLLV 04,SRLV 06,SRAV 07 -> RegDst=1 RegWrite=1 Shamt=0, ALUOp SLL/SRL/SRA.
//   ADD 20,ADDU 21,SUB 22,SUBU 23,AND 24,OR 25,XOR 26,NOR 27,SLT 2A -> RegDst=1 RegWrite=1.
//   JR 08 -> all 0 (ALUOp ADD). JALR 09 -> RegDst=1 RegWrite=1, ALUOp ADD.
//  Loads LB 20,LH 21,LW 23,LBU 24,LHU 25 -> RegWrite MemRead MemtoReg ALUSrc=1, ALUOp ADD.
//  Stores SB 28,SH 29,SW 2B -> MemWrite=1 ALUSrc=1, ALUOp ADD, RegWrite=0.
//  Immediates ADDI 08,SLTI 0A,ANDI 0C,ORI 0D,XORI 0E,LUI 0F -> RegWrite=1 ALUSrc=1,
//   ALUOp ADD/SLT/AND/OR/XOR/LUI respectively, RegDst=0.
//  Branches BEQ 04,BNE 05 -> ALUOp SUB, ALUSrc=0, no writes.
//  J 02 -> all 0 (ALUOp ADD). JAL 03 -> RegWrite=1, ALUOp ADD (link path external).
//  Undefined opcode, or op 00 with undefined funct -> all outputs 0 (NOP).
//  funct ignored for op!=00. rst has priority over i_control_mux.
//  Reset asserted mid-stream: next edge outputs 0; first decode one edge after rst drops.
// CONFIGURATION
//  CONTROL_ILLEGAL_DETECT_EN defined: o_illegal port exists, registered with other outputs,
//   =1 for undefined opcode/funct with i_control_mux=1; 0 on reset and on bubble.
//  Not defined: port absent; undefined encodings decode silently to NOP.
// TESTING
//  rst=1 one edge -> all outputs 0; hold rst, any opcode -> still 0.
//  op=00 funct=20, mux=1 -> next edge RegDst=1 RegWrite=1 ALUOp=3 ALUSrc=0 Shamt=0.
//  op=00 funct=00 -> Shamt=1 ALUOp=0; funct=04 -> Shamt=0 ALUOp=0.
//  op=25 (LHU) -> RegWrite MemRead MemtoReg ALUSrc=1 ALUOp=3 ls_filter_op=100.
//  op=29 (SH) -> MemWrite=1 ALUSrc=1 RegWrite=0 ls_filter_op=001; then mux=0 -> all 0.
//  op=3F -> all 0; with CONTROL_ILLEGAL_DETECT_EN, o_illegal=1 one edge later.

Source files
------------

// File: rtl/control_unit.sv
// MIPS ID-stage main decoder with registered ID/EX controls and bubble insertion.
// Optional o_illegal flag is built when CONTROL_ILLEGAL_DETECT_EN is defined.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_control_mux,
    output logic       o_RegDst,
    output logic       o_RegWrite,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_MemtoReg,
    output logic [3:0] o_ALUOp,
    output logic       o_ALUSrc,
    output logic       o_Shamt,
    output logic [2:0] o_ls_filter_op
`ifdef CONTROL_ILLEGAL_DETECT_EN
    ,
    output logic       o_illegal
`endif
);

    localparam logic [3:0] ALU_SLL  = 4'h0;
    localparam logic [3:0] ALU_SRL  = 4'h1;
    localparam logic [3:0] ALU_SRA  = 4'h2;
    localparam logic [3:0] ALU_ADD  = 4'h3;
    localparam logic [3:0] ALU_SUB  = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_XOR  = 4'h7;
    localparam logic [3:0] ALU_NOR  = 4'h8;
    localparam logic [3:0] ALU_SLT  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hA;
    localparam logic [3:0] ALU_ADDU = 4'hB;
    localparam logic [3:0] ALU_SUBU = 4'hC;

    logic       w_regdst, w_regwrite, w_memread, w_memwrite, w_memtoreg;
    logic       w_alusrc, w_shamt, w_legal;
    logic [3:0] w_aluop;
    logic [2:0] w_filter;

    always_comb begin
        w_regdst   = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_shamt    = 1'b0;
        w_legal    = 1'b1;
        w_aluop    = ALU_ADD;
        w_filter   = 3'b010;
        case (i_opcode)
            6'h00: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                case (i_funct)
                    6'h00: begin w_aluop = ALU_SLL; w_shamt = 1'b1; end
                    6'h02: begin w_aluop = ALU_SRL; w_shamt = 1'b1; end
                    6'h03: begin w_aluop = ALU_SRA; w_shamt = 1'b1; end
                    6'h04: w_aluop = ALU_SLL;
                    6'h06: w_aluop = ALU_SRL;
                    6'h07: w_aluop = ALU_SRA;
                    6'h20: w_aluop = ALU_ADD;
                    6'h21: w_aluop = ALU_ADDU;
                    6'h22: w_aluop = ALU_SUB;
                    6'h23: w_aluop = ALU_SUBU;
                    6'h24: w_aluop = ALU_AND;
                    6'h25: w_aluop = ALU_OR;
                    6'h26: w_aluop = ALU_XOR;
                    6'h27: w_aluop = ALU_NOR;
                    6'h2A: w_aluop = ALU_SLT;
                    6'h08: begin w_regdst = 1'b0; w_regwrite = 1'b0; end
                    6'h09: w_aluop = ALU_ADD;
                    default: w_legal = 1'b0;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_alusrc   = 1'b1;
                case (i_opcode)
                    6'h20:   w_filter = 3'b000;
                    6'h21:   w_filter = 3'b001;
                    6'h24:   w_filter = 3'b011;
                    6'h25:   w_filter = 3'b100;
                    default: w_filter = 3'b010;
                endcase
            end
            6'h28, 6'h29, 6'h2B: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                case (i_opcode)
                    6'h28:   w_filter = 3'b000;
                    6'h29:   w_filter = 3'b001;
                    default: w_filter = 3'b010;
                endcase
            end
            6'h08: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_ADD; end
            6'h0A: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_SLT; end
            6'h0C: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_AND; end
            6'h0D: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_OR;  end
            6'h0E: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_XOR; end
            6'h0F: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_LUI; end
            6'h04, 6'h05: w_aluop = ALU_SUB;
            6'h02: w_aluop = ALU_ADD;
            6'h03: w_regwrite = 1'b1;
            default: w_legal = 1'b0;
        endcase
        // Undefined encodings collapse to a true all-zero NOP, not the defaults
        if (!w_legal) begin
            w_regdst   = 1'b0;
            w_regwrite = 1'b0;
            w_memread  = 1'b0;
            w_memwrite = 1'b0;
            w_memtoreg = 1'b0;
            w_alusrc   = 1'b0;
            w_shamt    = 1'b0;
            w_aluop    = 4'h0;
            w_filter   = 3'b000;
        end
    end

    logic w_load;
    assign w_load = !rst && i_control_mux;

    always_ff @(posedge clk) begin
        o_RegDst       <= w_load ? w_regdst   : 1'b0;
        o_RegWrite     <= w_load ? w_regwrite : 1'b0;
        o_MemRead      <= w_load ? w_memread  : 1'b0;
        o_MemWrite     <= w_load ? w_memwrite : 1'b0;
        o_MemtoReg     <= w_load ? w_memtoreg : 1'b0;
        o_ALUOp        <= w_load ? w_aluop    : 4'h0;
        o_ALUSrc       <= w_load ? w_alusrc   : 1'b0;
        o_Shamt        <= w_load ? w_shamt    : 1'b0;
        o_ls_filter_op <= w_load ? w_filter   : 3'b000;
    end

`ifdef CONTROL_ILLEGAL_DETECT_EN
    always_ff @(posedge clk) begin
        o_illegal <= w_load && !w_legal;
    end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against an opcode/funct lookup-table model.
// Checks o_illegal too when CONTROL_ILLEGAL_DETECT_EN is defined.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] fn = 6'h00;
    logic       mux = 1'b0;

    logic       RegDst, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Shamt;
    logic [3:0] ALUOp;
    logic [2:0] filt;
    logic       ill;

    int n_chk = 0;
    int n_err = 0;

    // Bundle: [14]=illegal [13]RegDst [12]RegWrite [11]MemRead [10]MemWrite
    // [9]MemtoReg [8:5]ALUOp [4]ALUSrc [3]Shamt [2:0]filter
    logic [14:0] otab [64];
    logic [14:0] rtab [64];

    always #5 clk = ~clk;

    control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_opcode       (op),
        .i_funct        (fn),
        .i_control_mux  (mux),
        .o_RegDst       (RegDst),
        .o_RegWrite     (RegWrite),
        .o_MemRead      (MemRead),
        .o_MemWrite     (MemWrite),
        .o_MemtoReg     (MemtoReg),
        .o_ALUOp        (ALUOp),
        .o_ALUSrc       (ALUSrc),
        .o_Shamt        (Shamt),
        .o_ls_filter_op (filt)
`ifdef CONTROL_ILLEGAL_DETECT_EN
        ,
        .o_illegal      (ill)
`endif
    );

`ifndef CONTROL_ILLEGAL_DETECT_EN
    assign ill = 1'b0;
`endif

    function automatic logic [14:0] mk(
        input logic rd, input logic rw, input logic mr, input logic mw,
        input logic m2r, input logic [3:0] alu, input logic src,
        input logic sh, input logic [2:0] f);
        return {1'b0, rd, rw, mr, mw, m2r, alu, src, sh, f};
    endfunction

    function automatic logic [14:0] model(
        input logic r, input logic [5:0] o, input logic [5:0] f, input logic m);
        logic [14:0] v;
        if (r || !m) return 15'h0;
        v = (o == 6'h00) ? rtab[f] : otab[o];
`ifndef CONTROL_ILLEGAL_DETECT_EN
        v[14] = 1'b0;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [14:0] got,
                       input logic [14:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [5:0] o,
                        input logic [5:0] f, input logic m);
        logic [14:0] e;
        @(negedge clk);
        rst = r; op = o; fn = f; mux = m;
        e = model(r, o, f, m);
        @(posedge clk);
        #1;
        chk(tag, {ill, RegDst, RegWrite, MemRead, MemWrite, MemtoReg,
                  ALUOp, ALUSrc, Shamt, filt}, e);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            otab[i] = 15'h4000;
            rtab[i] = 15'h4000;
        end
        rtab[6'h00] = mk(1, 1, 0, 0, 0, 4'h0, 0, 1, 3'b010);
        rtab[6'h02] = mk(1, 1, 0, 0, 0, 4'h1, 0, 1, 3'b010);
        rtab[6'h03] = mk(1, 1, 0, 0, 0, 4'h2, 0, 1, 3'b010);
        rtab[6'h04] = mk(1, 1, 0, 0, 0, 4'h0, 0, 0, 3'b010);
        rtab[6'h06] = mk(1, 1, 0, 0, 0, 4'h1, 0, 0, 3'b010);
        rtab[6'h07] = mk(1, 1, 0, 0, 0, 4'h2, 0, 0, 3'b010);
        rtab[6'h20] = mk(1, 1, 0, 0, 0, 4'h3, 0, 0, 3'b010);
        rtab[6'h21] = mk(1, 1, 0, 0, 0, 4'hB, 0, 0, 3'b010);
        rtab[6'h22] = mk(1, 1, 0, 0, 0, 4'h4, 0, 0, 3'b010);
        rtab[6'h23] = mk(1, 1, 0, 0, 0, 4'hC, 0, 0, 3'b010);
        rtab[6'h24] = mk(1, 1, 0, 0, 0, 4'h5, 0, 0, 3'b010);
        rtab[6'h25] = mk(1, 1, 0, 0, 0, 4'h6, 0, 0, 3'b010);
        rtab[6'h26] = mk(1, 1, 0, 0, 0, 4'h7, 0, 0, 3'b010);
        rtab[6'h27] = mk(1, 1, 0, 0, 0, 4'h8, 0, 0, 3'b010);
        rtab[6'h2A] = mk(1, 1, 0, 0, 0, 4'h9, 0, 0, 3'b010);
        rtab[6'h08] = mk(0, 0, 0, 0, 0, 4'h3, 0, 0, 3'b010);
        rtab[6'h09] = mk(1, 1, 0, 0, 0, 4'h3, 0, 0, 3'b010);
        otab[6'h20] = mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 3'b000);
        otab[6'h21] = mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 3'b001);
        otab[6'h23] = mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 3'b010);
        otab[6'h24] = mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 3'b011);
        otab[6'h25] = mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 3'b100);
        otab[6'h28] = mk(0, 0, 0, 1, 0, 4'h3, 1, 0, 3'b000);
        otab[6'h29] = mk(0, 0, 0, 1, 0, 4'h3, 1, 0, 3'b001);
        otab[6'h2B] = mk(0, 0, 0, 1, 0, 4'h3, 1, 0, 3'b010);
        otab[6'h08] = mk(0, 1, 0, 0, 0, 4'h3, 1, 0, 3'b010);
        otab[6'h0A] = mk(0, 1, 0, 0, 0, 4'h9, 1, 0, 3'b010);
        otab[6'h0C] = mk(0, 1, 0, 0, 0, 4'h5, 1, 0, 3'b010);
        otab[6'h0D] = mk(0, 1, 0, 0, 0, 4'h6, 1, 0, 3'b010);
        otab[6'h0E] = mk(0, 1, 0, 0, 0, 4'h7, 1, 0, 3'b010);
        otab[6'h0F] = mk(0, 1, 0, 0, 0, 4'hA, 1, 0, 3'b010);
        otab[6'h04] = mk(0, 0, 0, 0, 0, 4'h4, 0, 0, 3'b010);
        otab[6'h05] = mk(0, 0, 0, 0, 0, 4'h4, 0, 0, 3'b010);
        otab[6'h02] = mk(0, 0, 0, 0, 0, 4'h3, 0, 0, 3'b010);
        otab[6'h03] = mk(0, 1, 0, 0, 0, 4'h3, 0, 0, 3'b010);

        step("reset", 1, 6'h00, 6'h20, 1);
        step("reset_hold_lw", 1, 6'h23, 6'h00, 1);
        step("reset_hold_ill", 1, 6'h3F, 6'h3F, 1);
        step("add", 0, 6'h00, 6'h20, 1);
        step("sll", 0, 6'h00, 6'h00, 1);
        step("sllv", 0, 6'h00, 6'h04, 1);
        step("sra", 0, 6'h00, 6'h03, 1);
        step("subu", 0, 6'h00, 6'h23, 1);
        step("jr", 0, 6'h00, 6'h08, 1);
        step("jalr", 0, 6'h00, 6'h09, 1);
        step("rfunct_bad", 0, 6'h00, 6'h3F, 1);
        step("lhu", 0, 6'h25, 6'h00, 1);
        step("lb", 0, 6'h20, 6'h15, 1);
        step("sh", 0, 6'h29, 6'h00, 1);
        step("bubble", 0, 6'h29, 6'h00, 0);
        step("beq", 0, 6'h04, 6'h2A, 1);
        step("lui", 0, 6'h0F, 6'h00, 1);
        step("j", 0, 6'h02, 6'h00, 1);
        step("jal", 0, 6'h03, 6'h00, 1);
        step("op3f", 0, 6'h3F, 6'h00, 1);
        step("rst_mid", 1, 6'h08, 6'h00, 1);
        step("after_rst", 0, 6'h08, 6'h00, 1);
        step("bubble_ill", 0, 6'h3F, 6'h00, 0);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] ro, rf;
            logic rr, rm;
            ro = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom_range(0, 63));
            rf = 6'($urandom_range(0, 63));
            rr = ($urandom_range(0, 19) == 0);
            rm = ($urandom_range(0, 6) != 0);
            step("rand", rr, ro, rf, rm);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
